stall_controller: RTL

//  Consumer end of the hazard-detection path. Takes the hazard request, memory handshake and branch

---
 rtl/stall_ctrl_pkg.sv | 24 ++
 rtl/sat_counter.sv | 36 +++
 rtl/stall_controller.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Optional feature macro: STALL_CTRL_PERF_EN (performance counters, see stall_controller).
package stall_ctrl_pkg;

    // Controller FSM: free-running pipe, or waiting on a multi-cycle memory access.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    // Which control rule is in effect this cycle, strongest first.
    localparam logic [1:0] PRIO_NONE   = 2'd0;
    localparam logic [1:0] PRIO_MEM    = 2'd1;
    localparam logic [1:0] PRIO_BRANCH = 2'd2;
    localparam logic [1:0] PRIO_HAZARD = 2'd3;

    // Defaults: watchdog length in MEM_WAIT cycles, and perf counter width.
    localparam int MEM_TIMEOUT_DEF = 256;
    localparam int CNT_W_DEF       = 32;

    // Wait counter width; large enough for the biggest legal timeout (65535).
    localparam int WAIT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones, clr returns to 0.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Next value: clear wins, otherwise increment unless already saturated.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && !(&value_q)) begin
            value_d = value_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller: turns hazard requests, the memory handshake and branch
// outcomes into freeze/flush controls for the four pipeline registers. A small FSM tracks
// multi-cycle memory waits and aborts a wait that runs for MEM_TIMEOUT cycles.
// Optional feature macro: STALL_CTRL_PERF_EN adds saturating cycle counters for hazard
// bubbles, memory stalls and branch flushes.
module stall_controller
    import stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_exe,
    output logic             freeze_mem,
    output logic             flush_if,
    output logic             flush_id,
    output logic             mem_err
`ifdef STALL_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cnt_hazard,
    output logic [CNT_W-1:0] cnt_mem,
    output logic [CNT_W-1:0] cnt_flush
`endif
);

    // Abort fires while the counter shows MEM_TIMEOUT-1 already-stalled cycles, so the
    // freezes are held for exactly MEM_TIMEOUT-1 cycles and released on the next one.
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic              mem_pending;
    logic              mem_err_abort;
    logic              mem_stall;
    logic [1:0]        prio;

    assign mem_pending   = (mem_r_en | mem_w_en) & ~mem_ready;
    assign mem_err_abort = (state_q == MEM_WAIT) & mem_pending & (wait_cnt_q == WAIT_LIMIT);
    assign mem_stall     = mem_pending & ~mem_err_abort;

    // Pick the strongest active rule; a stall masks branch/hazard, a branch masks hazard.
    always_comb begin
        prio = PRIO_NONE;
        if (mem_stall) begin
            prio = PRIO_MEM;
        end else if (branch_taken) begin
            prio = PRIO_BRANCH;
        end else if (hazard) begin
            prio = PRIO_HAZARD;
        end
    end

    // Decode the rule into pipeline controls; everything is forced low while in reset.
    always_comb begin
        freeze_if  = 1'b0;
        freeze_id  = 1'b0;
        freeze_exe = 1'b0;
        freeze_mem = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        if (!rst) begin
            case (prio)
                PRIO_MEM: begin
                    freeze_if  = 1'b1;
                    freeze_id  = 1'b1;
                    freeze_exe = 1'b1;
                    freeze_mem = 1'b1;
                end
                PRIO_BRANCH: begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                end
                PRIO_HAZARD: begin
                    freeze_if = 1'b1;
                    flush_id  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // FSM next state: sit in MEM_WAIT exactly while the stall is asserted. The wait counter
    // counts stalled cycles (the entering cycle included), saturating, and clears otherwise.
    always_comb begin
        state_d    = RUN;
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q | mem_err_abort;
        if (mem_stall) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    // FSM, wait counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q & ~rst;

`ifdef STALL_CTRL_PERF_EN
    sat_counter #(.W(CNT_W)) u_cnt_hazard (
        .clk   (clk),
        .rst   (rst),
        .inc   (prio == PRIO_HAZARD),
        .clr   (1'b0),
        .value (cnt_hazard)
    );

    sat_counter #(.W(CNT_W)) u_cnt_mem (
        .clk   (clk),
        .rst   (rst),
        .inc   (prio == PRIO_MEM),
        .clr   (1'b0),
        .value (cnt_mem)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst   (rst),
        .inc   (prio == PRIO_BRANCH),
        .clr   (1'b0),
        .value (cnt_flush)
    );
`endif

endmodule
